// File: rtl/spi_txn_arbiter_if.sv
// Requester, arbiter and SPI byte-engine signal bundle for spi_txn_arbiter.
// slave = arbiter side, master = requesters plus engine side.
interface spi_txn_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] tx_ack;
  logic [7:0] rx_data;
  logic [1:0] rx_valid;
  logic [1:0] done;
  logic [1:0] gnt;
  logic [1:0] cs_n;
  logic [7:0] eng_data;
  logic       eng_load;
  logic       eng_busy;
  logic [7:0] eng_rx;

  modport slave (
    input  req, len0, len1, tx_data0, tx_data1, eng_busy, eng_rx,
    output tx_ack, rx_data, rx_valid, done, gnt, cs_n, eng_data, eng_load
  );

  modport master (
    output req, len0, len1, tx_data0, tx_data1, eng_busy, eng_rx,
    input  tx_ack, rx_data, rx_valid, done, gnt, cs_n, eng_data, eng_load
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Two-requester SPI transaction arbiter: grants one requester a chip-selected burst of 1..16 bytes.
// Define SPI_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0 first) otherwise.
module spi_txn_arbiter #(
  parameter int unsigned CS_GAP = 2
) (
  input logic              clk,
  input logic              rst,
  spi_txn_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT_HI, WAIT_LO, GAP} state_t;

  // The done cycle is the first GAP cycle and the IDLE cycle also keeps cs_n high,
  // so the GAP counter covers CS_GAP states in total.
  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);

  state_t     r_state;
  logic [3:0] r_count;
  logic [3:0] r_gap;
  logic       r_win;
  logic [1:0] r_gnt;
  logic [1:0] r_cs_n;
  logic [1:0] r_tx_ack;
  logic [1:0] r_rx_valid;
  logic [1:0] r_done;
  logic [7:0] r_rx_data;
  logic [7:0] r_eng_data;
  logic       r_eng_load;

  logic       w_pick;
  logic [1:0] w_win_oh;
  logic [7:0] w_tx_data;
  logic [3:0] w_len;

`ifdef SPI_ARB_RR_EN
  logic r_ptr;

  always_comb begin
    if (bus.req == 2'b11) w_pick = ~r_ptr;
    else                  w_pick = ~bus.req[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_ptr <= 1'b1;
    else if (r_state == IDLE && bus.req != 2'b00) r_ptr <= w_pick;
  end
`else
  assign w_pick = ~bus.req[0];
`endif

  assign w_win_oh  = {r_win, ~r_win};
  assign w_tx_data = r_win ? bus.tx_data1 : bus.tx_data0;
  assign w_len     = w_pick ? bus.len1 : bus.len0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= 4'd0;
      r_gap      <= 4'd0;
      r_win      <= 1'b0;
      r_gnt      <= 2'b00;
      r_cs_n     <= 2'b11;
      r_tx_ack   <= 2'b00;
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;
      r_rx_data  <= 8'd0;
      r_eng_data <= 8'd0;
      r_eng_load <= 1'b0;
    end else begin
      r_tx_ack   <= 2'b00;
      r_rx_valid <= 2'b00;
      r_done     <= 2'b00;
      r_eng_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            r_win   <= w_pick;
            r_gnt   <= {w_pick, ~w_pick};
            r_cs_n  <= {~w_pick, w_pick};
            r_count <= w_len;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_eng_load <= 1'b1;
          r_eng_data <= w_tx_data;
          r_tx_ack   <= w_win_oh;
          r_state    <= LOAD;
        end
        LOAD: r_state <= WAIT_HI;
        WAIT_HI: begin
          if (bus.eng_busy) r_state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!bus.eng_busy) begin
            r_rx_data  <= bus.eng_rx;
            r_rx_valid <= w_win_oh;
            if (r_count == 4'd0) begin
              r_done  <= w_win_oh;
              r_gap   <= GAP_LAST;
              r_state <= GAP;
            end else begin
              // Next byte loads straight away; cs_n stays low across the burst.
              r_count    <= r_count - 4'd1;
              r_eng_load <= 1'b1;
              r_eng_data <= w_tx_data;
              r_tx_ack   <= w_win_oh;
              r_state    <= LOAD;
            end
          end
        end
        GAP: begin
          r_gnt  <= 2'b00;
          r_cs_n <= 2'b11;
          if (r_gap == 4'd0) r_state <= IDLE;
          else               r_gap   <= r_gap - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.cs_n     = r_cs_n;
  assign bus.tx_ack   = r_tx_ack;
  assign bus.rx_valid = r_rx_valid;
  assign bus.done     = r_done;
  assign bus.rx_data  = r_rx_data;
  assign bus.eng_data = r_eng_data;
  assign bus.eng_load = r_eng_load;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed vector table, reset/gap sequences, random traffic.
// Expectations follow SPI_ARB_RR_EN when the bench is built with it.
module tb_spi_txn_arbiter;

  localparam int GAP = 3;
`ifdef SPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [1:0] reqPat;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [7:0] base0;
    logic [7:0] base1;
    logic [7:0] step;
    bit         dropEarly;
    bit         changeLen;
    logic [1:0] reqAfter;
    int         expWinFixed;
    int         expWinRr;
    int         expBytes;
    int         expPre;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   fails = 0;
  int   engLat = 1;
  int   engBusy = 3;
  int   lastWinner = 1;
  logic [7:0] engCapt;
  vec_t vecs [7];

  spi_txn_arbiter_if bus ();

  spi_txn_arbiter #(.CS_GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte engine: busy for a while after each load, then returns the byte XOR 0x99.
  initial begin
    bus.eng_busy = 1'b0;
    bus.eng_rx   = 8'd0;
    forever begin
      @(negedge clk);
      if (bus.eng_load) begin
        engCapt = bus.eng_data;
        repeat (engLat) @(negedge clk);
        bus.eng_busy = 1'b1;
        repeat (engBusy) @(negedge clk);
        bus.eng_rx   = engCapt ^ 8'h99;
        bus.eng_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int modelWinner(input logic [1:0] r, input int last);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return RR ? (1 - last) : 0;
  endfunction

  // Runs one transaction from request to done and checks it against the expected winner and byte count.
  task automatic applyStimulus(input string tag, input vec_t v, input int w, input int expBytes,
                               output int preCycles);
    logic [1:0] oh;
    logic [7:0] strm [17];
    int loads, acks, rxv, dones, dataErrs, csErrs, hotErrs, gotWin;
    bit granted;
    oh = (w == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < 17; k++) strm[k] = ((w == 1) ? v.base1 : v.base0) + 8'(k) * v.step;
    loads = 0; acks = 0; rxv = 0; dones = 0; dataErrs = 0; csErrs = 0; hotErrs = 0;
    gotWin = -1; granted = 1'b0; preCycles = 0;
    bus.len0     = v.l0;
    bus.len1     = v.l1;
    bus.tx_data0 = v.base0;
    bus.tx_data1 = v.base1;
    bus.req      = v.reqPat;
    for (int cyc = 0; cyc < 3000 && dones == 0; cyc++) begin
      @(negedge clk);
      if (!$onehot0(bus.gnt) || !$onehot0(~bus.cs_n)) hotErrs++;
      if (!granted && bus.gnt != 2'b00) begin
        granted = 1'b1;
        gotWin  = bus.gnt[1] ? 1 : 0;
        if (v.changeLen) begin
          if (w == 1) bus.len1 = ~v.l1;
          else        bus.len0 = ~v.l0;
        end
      end
      if (!granted) begin
        preCycles++;
        if (bus.cs_n != 2'b11) csErrs++;
      end else if (bus.gnt != oh || bus.cs_n != ~oh) begin
        csErrs++;
      end
      if (bus.eng_load) begin
        if (loads >= 17 || bus.eng_data != strm[loads]) dataErrs++;
        loads++;
      end
      if (bus.tx_ack != 2'b00) begin
        if (bus.tx_ack != oh) dataErrs++;
        acks++;
        if (acks < 17) begin
          if (w == 1) bus.tx_data1 = strm[acks];
          else        bus.tx_data0 = strm[acks];
        end
        if (v.dropEarly && acks == 1) bus.req = bus.req & ~oh;
      end
      if (bus.rx_valid != 2'b00) begin
        if (bus.rx_valid != oh || rxv >= 17 || bus.rx_data != (strm[rxv] ^ 8'h99)) dataErrs++;
        rxv++;
      end
      if (bus.done != 2'b00) begin
        if (bus.done != oh || bus.rx_valid != oh) dataErrs++;
        dones++;
        bus.req = v.reqAfter;
      end
    end
    checkOutput({tag, ".winner"}, gotWin, w);
    checkOutput({tag, ".loads"}, loads, expBytes);
    checkOutput({tag, ".txAcks"}, acks, expBytes);
    checkOutput({tag, ".rxValids"}, rxv, expBytes);
    checkOutput({tag, ".dones"}, dones, 1);
    checkOutput({tag, ".dataErrs"}, dataErrs, 0);
    checkOutput({tag, ".csGntErrs"}, csErrs, 0);
    checkOutput({tag, ".oneHotErrs"}, hotErrs, 0);
    lastWinner = w;
  endtask

  initial begin
    int pre;
    int w;
    int expB;
    int lds;
    int badCnt;
    vec_t rv;

    //            req    l0  l1  base0  base1  step   drop  chg   after  wFix wRr bytes pre
    vecs[0] = '{2'b01, 0,  0,  8'hA5, 8'h50, 8'h11, 1'b0, 1'b0, 2'b00, 0, 0, 1,  0};
    vecs[1] = '{2'b10, 0,  2,  8'h60, 8'h11, 8'h11, 1'b0, 1'b0, 2'b00, 1, 1, 3,  -1};
    vecs[2] = '{2'b11, 0,  0,  8'h01, 8'h81, 8'h01, 1'b0, 1'b0, 2'b11, 0, 0, 1,  -1};
    vecs[3] = '{2'b11, 0,  0,  8'h02, 8'h82, 8'h01, 1'b0, 1'b0, 2'b00, 0, 1, 1,  GAP};
    vecs[4] = '{2'b01, 3,  0,  8'hC0, 8'h00, 8'h07, 1'b1, 1'b0, 2'b00, 0, 0, 4,  -1};
    vecs[5] = '{2'b10, 0,  5,  8'h00, 8'h30, 8'h13, 1'b0, 1'b1, 2'b00, 1, 1, 6,  -1};
    vecs[6] = '{2'b01, 15, 0,  8'hF0, 8'h00, 8'h0B, 1'b0, 1'b0, 2'b00, 0, 0, 16, -1};

    rst = 1'b0;
    bus.req = 2'b00; bus.len0 = 4'd0; bus.len1 = 4'd0;
    bus.tx_data0 = 8'd0; bus.tx_data1 = 8'd0;
    #1 rst = 1'b1;
    #10;
    checkOutput("reset.csGnt", {bus.cs_n, bus.gnt}, 4'b1100);
    checkOutput("reset.pulses", {bus.tx_ack, bus.rx_valid, bus.done, bus.eng_load}, 7'd0);
    checkOutput("reset.data", {bus.eng_data, bus.rx_data}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    lastWinner = 1;

    for (int i = 0; i < 7; i++) begin
      w = RR ? vecs[i].expWinRr : vecs[i].expWinFixed;
      applyStimulus($sformatf("vec%0d", i), vecs[i], w, vecs[i].expBytes, pre);
      if (vecs[i].expPre >= 0) checkOutput($sformatf("vec%0d.preGrantCycles", i), pre, vecs[i].expPre);
      if (i == 0) checkOutput("vec0.rxEcho", bus.rx_data, 8'h3C);
    end

    // Reset while byte 2 of 4 is in WAIT_LO.
    bus.req = 2'b01; bus.len0 = 4'd3; bus.tx_data0 = 8'h40;
    lds = 0;
    for (int cyc = 0; cyc < 200 && lds < 2; cyc++) begin
      @(negedge clk);
      if (bus.eng_load) lds++;
    end
    checkOutput("midReset.secondLoad", lds, 2);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    bus.req = 2'b00;
    #1;
    checkOutput("midReset.csGnt", {bus.cs_n, bus.gnt}, 4'b1100);
    checkOutput("midReset.pulses", {bus.tx_ack, bus.rx_valid, bus.done, bus.eng_load}, 7'd0);
    checkOutput("midReset.data", {bus.eng_data, bus.rx_data}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    lastWinner = 1;
    badCnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done != 2'b00 || bus.gnt != 2'b00 || bus.cs_n != 2'b11) badCnt++;
    end
    checkOutput("midReset.quiet", badCnt, 0);
    rv = '{2'b01, 1, 0, 8'h5A, 8'h00, 8'h21, 1'b0, 1'b0, 2'b00, 0, 0, 2, 0};
    applyStimulus("afterReset", rv, 0, 2, pre);
    checkOutput("afterReset.preGrantCycles", pre, 0);

    for (int i = 0; i < 30; i++) begin
      rv.reqPat    = 2'($urandom_range(1, 3));
      rv.l0        = 4'($urandom_range(0, 15));
      rv.l1        = 4'($urandom_range(0, 15));
      rv.base0     = 8'($urandom);
      rv.base1     = 8'($urandom);
      rv.step      = 8'($urandom);
      rv.dropEarly = 1'($urandom_range(0, 1));
      rv.changeLen = 1'($urandom_range(0, 1));
      rv.reqAfter  = 2'b00;
      engLat       = $urandom_range(0, 2);
      engBusy      = $urandom_range(2, 4);
      w    = modelWinner(rv.reqPat, lastWinner);
      expB = ((w == 1) ? int'(rv.l1) : int'(rv.l0)) + 1;
      applyStimulus($sformatf("rand%0d", i), rv, w, expB, pre);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/spi_txn_arbiter.md
SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

Interface
REQ-001 Parameter: CS_GAP, default 2, idle cycles with all chip selects high between transactions (range 1..15).
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req  input  2  per-requester transaction request; held high until the matching done pulse.
REQ-005 len0, len1  input  4 each  byte count minus 1 for requester 0/1; sampled at grant.
REQ-006 tx_data0, tx_data1  input  8 each  next byte to send for requester 0/1.
REQ-007 tx_ack  output  2  one-cycle pulse: the granted requester's tx_data was consumed.
REQ-008 rx_data  output  8  last byte received from the engine.
REQ-009 rx_valid  output  2  one-cycle pulse to the granted requester: rx_data is valid.
REQ-010 done  output  2  one-cycle pulse: the granted requester's transaction has completed.
REQ-011 gnt  output  2  one-hot grant, high from grant until the done cycle inclusive.
REQ-012 cs_n  output  2  per-slave chip select, active-low; slave index equals requester index.
REQ-013 eng_data  output  8  byte to the SPI byte engine.
REQ-014 eng_load  output  1  one-cycle pulse that starts one engine byte transfer.
REQ-015 eng_busy  input  1  engine transfer in progress.
REQ-016 eng_rx  input  8  byte received by the engine; valid when eng_busy falls.

Function
REQ-017 The FSM states SHALL be IDLE, SETUP, LOAD, WAIT_HI, WAIT_LO, GAP.
REQ-018 IDLE: when any req bit is high, the FSM picks a winner, sets gnt, drives cs_n[winner] low, latches len into an internal 4-bit count, and goes to SETUP on the next cycle.
REQ-019 SETUP: one cycle with cs_n low and no load (CS setup time), then LOAD.
REQ-020 LOAD: one cycle with eng_load=1, eng_data=tx_data of the winner, and tx_ack[winner]=1, then WAIT_HI.
REQ-021 WAIT_HI: the FSM stays until eng_busy=1, then goes to WAIT_LO.
REQ-022 WAIT_LO: on the first cycle with eng_busy=0, the FSM registers eng_rx into rx_data and pulses rx_valid[winner] in the following cycle; if count=0 it goes to GAP, otherwise it decrements count and goes to LOAD.
REQ-023 On the transition to GAP, done[winner] SHALL pulse in the same cycle as the final rx_valid; gnt clears and cs_n returns to 2'b11 in the following cycle.
REQ-024 GAP: the FSM holds for CS_GAP cycles with cs_n=2'b11 and gnt=0, then returns to IDLE; requests that arrive during GAP wait.
REQ-025 cs_n SHALL stay low continuously from SETUP through the done cycle, with no deassertion between bytes.
REQ-026 Default arbitration is fixed priority, with req[0] winning over req[1].
REQ-027 A req drop mid-transaction SHALL be ignored; the transaction runs to its full len+1 bytes.
REQ-028 A len change after grant SHALL have no effect on the current transaction.
REQ-029 At most one gnt bit and at most one cs_n bit SHALL be active at any time.
REQ-030 Transaction byte count SHALL be len+1, giving a range of 1..16 bytes.

Reset
REQ-031 Asserting rst at any time, including mid-transfer, SHALL immediately set state=IDLE, cs_n=2'b11, gnt=0, tx_ack=0, rx_valid=0, done=0, eng_load=0, eng_data=0, rx_data=0, count=0, and the round-robin pointer to 1.
REQ-032 After rst deasserts, the first arbitration SHALL take place on the first clock edge with req≠0.

Configuration
REQ-033 With SPI_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer records the last winner, and when both req bits are high the other requester wins.
REQ-034 With SPI_ARB_RR_EN undefined, arbitration SHALL be fixed priority per REQ-026, and no pointer register exists.

Verification
REQ-035 Single byte: req=01, len0=0, tx_data0=0xA5, engine echoes 0x3C -> one eng_load with eng_data=0xA5; rx_data=0x3C with rx_valid=01; done=01; cs_n[0] low for the whole transaction.
REQ-036 Multi-byte: req=10, len1=2, bytes 0x11/0x22/0x33 -> three eng_load pulses, three tx_ack[1] pulses, three rx_valid[1] pulses, one done[1] pulse; cs_n[1] never rises between bytes.
REQ-037 Contention: req=11 held for two transactions with len=0 -> fixed priority gives grant order 0,0; with SPI_ARB_RR_EN defined the order is 0,1.
REQ-038 Gap: back-to-back requests with CS_GAP=3 -> exactly 3 cycles with cs_n=11 between the done cycle+1 and the next SETUP.
REQ-039 Reset mid-transfer: rst asserted during WAIT_LO of byte 2 of 4 -> cs_n=11 and gnt=0 in the same cycle, with no done pulse; a new req=01 then completes normally.
REQ-040 Req drop: req[0] deasserted after the first tx_ack with len0=3 -> all 4 bytes are transferred and done[0] pulses.
